// File: rtl/vga_timing_generator_if.sv
// rtl/vga_timing_generator_if.sv - raster timing bundle from the timing generator to the pixel pipeline and DAC
interface vga_timing_generator_if;
    logic [9:0] x_pixel_coord_o;
    logic [9:0] y_pixel_coord_o;
    logic       is_inside_visible_region_o;
    logic       frame_start_o;
    logic       line_end_o;
    logic [7:0] frame_count_o;
    logic       hsync_n_o;
    logic       vsync_n_o;
    logic       blank_n_o;

    modport master (
        output x_pixel_coord_o, y_pixel_coord_o, is_inside_visible_region_o,
               frame_start_o, line_end_o, frame_count_o,
               hsync_n_o, vsync_n_o, blank_n_o
    );

    modport slave (
        input  x_pixel_coord_o, y_pixel_coord_o, is_inside_visible_region_o,
               frame_start_o, line_end_o, frame_count_o,
               hsync_n_o, vsync_n_o, blank_n_o
    );
endinterface

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - free-running 640x480@60 raster counters, strobes and delayed DAC syncs
module vga_timing_generator #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    vga_timing_generator_if.master        vga
);
    localparam logic [9:0] H_LAST      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0] H_VIS_LAST  = 10'(H_VISIBLE - 1);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       vis_nxt;
    logic       frame_start_nxt;
    logic       line_end_nxt;
    logic       hsync_n_nxt;
    logic       vsync_n_nxt;
    logic       hsync_n_raw;
    logic       vsync_n_raw;
    logic [2:0] sync_raw;

    // Flags are decoded from the next counts so they land on the same edge as the coordinates.
    always_comb begin
        x_nxt = (vga.x_pixel_coord_o == H_LAST) ? 10'd0 : vga.x_pixel_coord_o + 10'd1;
        y_nxt = vga.y_pixel_coord_o;
        if (vga.x_pixel_coord_o == H_LAST) begin
            y_nxt = (vga.y_pixel_coord_o == V_LAST) ? 10'd0 : vga.y_pixel_coord_o + 10'd1;
        end
        vis_nxt         = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        frame_start_nxt = (x_nxt == 10'd0) && (y_nxt == 10'd0);
        line_end_nxt    = (x_nxt == H_VIS_LAST) && (y_nxt < V_VIS);
        hsync_n_nxt     = !((x_nxt >= H_SYNC_BEG) && (x_nxt < H_SYNC_END));
        vsync_n_nxt     = !((y_nxt >= V_SYNC_BEG) && (y_nxt < V_SYNC_END));
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            vga.x_pixel_coord_o            <= H_LAST;
            vga.y_pixel_coord_o            <= V_LAST;
            vga.is_inside_visible_region_o <= 1'b0;
            vga.frame_start_o              <= 1'b0;
            vga.line_end_o                 <= 1'b0;
            vga.frame_count_o              <= 8'd0;
            hsync_n_raw                    <= 1'b1;
            vsync_n_raw                    <= 1'b1;
        end else begin
            vga.x_pixel_coord_o            <= x_nxt;
            vga.y_pixel_coord_o            <= y_nxt;
            vga.is_inside_visible_region_o <= vis_nxt;
            vga.frame_start_o              <= frame_start_nxt;
            vga.line_end_o                 <= line_end_nxt;
            vga.frame_count_o              <= vga.frame_count_o + 8'(frame_start_nxt);
            hsync_n_raw                    <= hsync_n_nxt;
            vsync_n_raw                    <= vsync_n_nxt;
        end
    end

    assign sync_raw = {hsync_n_raw, vsync_n_raw, vga.is_inside_visible_region_o};

    // DAC-side delay matches the colour read latency of the line memory.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign {vga.hsync_n_o, vga.vsync_n_o, vga.blank_n_o} = sync_raw;
        end else begin : g_delay
            logic [2:0] pipe [SYNC_DELAY];

            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        pipe[i] <= 3'b110;
                    end
                end else begin
                    pipe[0] <= sync_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign {vga.hsync_n_o, vga.vsync_n_o, vga.blank_n_o} = pipe[SYNC_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - checks full-size and reduced-raster generators against a cycle-count model
module tb_vga_timing_generator;
    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    int total = 0;
    int bad   = 0;
    int n     = 0;
    bit in_rst = 1'b1;

    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 2;
    localparam int SFT = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

    vga_timing_generator_if if_def ();
    vga_timing_generator_if if_s0 ();
    vga_timing_generator_if if_s3 ();

    vga_timing_generator #(.SYNC_DELAY(1)) u_def (
        .clock_i(clock_i), .reset_i(reset_i), .vga(if_def)
    );
    vga_timing_generator #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(0)
    ) u_s0 (
        .clock_i(clock_i), .reset_i(reset_i), .vga(if_s0)
    );
    vga_timing_generator #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(3)
    ) u_s3 (
        .clock_i(clock_i), .reset_i(reset_i), .vga(if_s3)
    );

    logic [33:0] o_def, o_s0, o_s3;
    assign o_def = {if_def.x_pixel_coord_o, if_def.y_pixel_coord_o, if_def.is_inside_visible_region_o,
                    if_def.frame_start_o, if_def.line_end_o, if_def.frame_count_o,
                    if_def.hsync_n_o, if_def.vsync_n_o, if_def.blank_n_o};
    assign o_s0  = {if_s0.x_pixel_coord_o, if_s0.y_pixel_coord_o, if_s0.is_inside_visible_region_o,
                    if_s0.frame_start_o, if_s0.line_end_o, if_s0.frame_count_o,
                    if_s0.hsync_n_o, if_s0.vsync_n_o, if_s0.blank_n_o};
    assign o_s3  = {if_s3.x_pixel_coord_o, if_s3.y_pixel_coord_o, if_s3.is_inside_visible_region_o,
                    if_s3.frame_start_o, if_s3.line_end_o, if_s3.frame_count_o,
                    if_s3.hsync_n_o, if_s3.vsync_n_o, if_s3.blank_n_o};

    // Expected outputs from the number of edges since reset release (n=0 is the first edge).
    function automatic logic [33:0] model(int cyc, bit rst, int hv, int hf, int hs, int hb,
                                          int vv, int vf, int vs, int vb, int d);
        int ht, vt, x, y, fc, m, xm, ym;
        bit vis, fs, le, h, v, b;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (rst) return {10'(ht - 1), 10'(vt - 1), 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0};
        x   = cyc % ht;
        y   = (cyc / ht) % vt;
        fc  = (cyc / (ht * vt) + 1) % 256;
        vis = (x < hv) && (y < vv);
        fs  = (x == 0) && (y == 0);
        le  = (x == hv - 1) && (y < vv);
        m   = cyc - d;
        if (m < 0) begin
            h = 1'b1; v = 1'b1; b = 1'b0;
        end else begin
            xm = m % ht;
            ym = (m / ht) % vt;
            h  = !((xm >= hv + hf) && (xm < hv + hf + hs));
            v  = !((ym >= vv + vf) && (ym < vv + vf + vs));
            b  = (xm < hv) && (ym < vv);
        end
        return {10'(x), 10'(y), vis, fs, le, 8'(fc), h, v, b};
    endfunction

    task automatic check_all();
        logic [33:0] e;
        e = model(n, in_rst, 640, 16, 96, 48, 480, 10, 2, 33, 1);
        total++;
        assert (o_def === e) else begin
            bad++; $error("FAIL cyc_def n=%0d rst=%0d got=%h exp=%h", n, in_rst, o_def, e);
        end
        e = model(n, in_rst, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0);
        total++;
        assert (o_s0 === e) else begin
            bad++; $error("FAIL cyc_s0 n=%0d rst=%0d got=%h exp=%h", n, in_rst, o_s0, e);
        end
        e = model(n, in_rst, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 3);
        total++;
        assert (o_s3 === e) else begin
            bad++; $error("FAIL cyc_s3 n=%0d rst=%0d got=%h exp=%h", n, in_rst, o_s3, e);
        end
    endtask

    task automatic chk(string tag, int got, int exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(int cnt);
        repeat (cnt) begin
            @(posedge clock_i);
            if (reset_i) begin
                if (in_rst) begin
                    n = 0; in_rst = 1'b0;
                end else begin
                    n++;
                end
            end else begin
                in_rst = 1'b1;
            end
            #1;
            check_all();
        end
    endtask

    initial begin
        int c_le, c_hs, c_fs, c_vs, c_vis, c_hs0;
        #1 reset_i = 1'b0;
        #1 check_all();
        step(3);

        @(negedge clock_i) reset_i = 1'b1;
        c_le = 0; c_hs = 0;
        for (int i = 0; i < 800; i++) begin
            step(1);
            if (i == 0) begin
                chk("first_x", int'(if_def.x_pixel_coord_o), 0);
                chk("first_y", int'(if_def.y_pixel_coord_o), 0);
                chk("first_vis", int'(if_def.is_inside_visible_region_o), 1);
                chk("first_fs", int'(if_def.frame_start_o), 1);
                chk("first_fc", int'(if_def.frame_count_o), 1);
                chk("first_blank_d1", int'(if_def.blank_n_o), 0);
            end
            if (i == 1) chk("second_blank_d1", int'(if_def.blank_n_o), 1);
            c_le += int'(if_def.line_end_o);
            c_hs += int'(!if_def.hsync_n_o);
        end
        chk("line0_line_end_pulses", c_le, 1);
        chk("line0_hsync_low", c_hs, 96);
        chk("line0_last_x", int'(if_def.x_pixel_coord_o), 799);
        step(1);
        chk("line1_x", int'(if_def.x_pixel_coord_o), 0);
        chk("line1_y", int'(if_def.y_pixel_coord_o), 1);

        c_le = 0; c_fs = 0; c_vs = 0; c_vis = 0; c_hs0 = 0;
        for (int i = 0; i < SFT; i++) begin
            step(1);
            c_le  += int'(if_s0.line_end_o);
            c_fs  += int'(if_s0.frame_start_o);
            c_vs  += int'(!if_s0.vsync_n_o);
            c_vis += int'(if_s0.is_inside_visible_region_o);
            c_hs0 += int'(!if_s0.hsync_n_o);
        end
        chk("frame_line_end_pulses", c_le, SVV);
        chk("frame_start_pulses", c_fs, 1);
        chk("frame_vsync_low", c_vs, SVS * (SHV + SHF + SHS + SHB));
        chk("frame_visible", c_vis, SHV * SVV);
        chk("frame_hsync_low", c_hs0, SHS * (SVV + SVF + SVS + SVB));

        for (int r = 0; r < 3; r++) begin
            step($urandom_range(1500, 20));
            @(negedge clock_i) reset_i = 1'b0;
            in_rst = 1'b1;
            #1 check_all();
            step(3);
            @(negedge clock_i) reset_i = 1'b1;
            step(1);
            chk("restart_fc_def", int'(if_def.frame_count_o), 1);
            chk("restart_x_s3", int'(if_s3.x_pixel_coord_o), 0);
        end

        step(255 * SFT - 1);
        chk("pre_wrap_fc", int'(if_s0.frame_count_o), 255);
        chk("pre_wrap_x", int'(if_s0.x_pixel_coord_o), SHV + SHF + SHS + SHB - 1);
        chk("pre_wrap_y", int'(if_s0.y_pixel_coord_o), SVV + SVF + SVS + SVB - 1);
        step(1);
        chk("wrap_fc", int'(if_s0.frame_count_o), 0);
        chk("wrap_fs", int'(if_s0.frame_start_o), 1);
        step(SFT);
        chk("post_wrap_fc", int'(if_s0.frame_count_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Produces the 640x480@60 Hz raster timing that drives the pixel pipeline: registered x/y pixel coordinates, a visible-region flag, and per-frame/per-line strobes.
- Also drives the DAC-side hsync/vsync/blank signals.
- Sits directly upstream of the cellular-automaton stage, which consumes the coordinates and visible flag to address line memory and to schedule its writes.
- DAC-side signals are delayed by a parameterised number of cycles so they line up with pixel colour that returns from memory after a read latency.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_DELAY, 1, pipeline depth (0..4) applied to hsync_n_o/vsync_n_o/blank_n_o

Ports:
clock_i  input  1  pixel clock (25.175 MHz nominal)
reset_i  input  1  asynchronous, active-low reset
x_pixel_coord_o  output  10  horizontal counter, 0..H_TOTAL-1
y_pixel_coord_o  output  10  vertical counter, 0..V_TOTAL-1
is_inside_visible_region_o  output  1  1 when x<H_VISIBLE and y<V_VISIBLE
frame_start_o  output  1  one-cycle pulse when coords become (0,0)
line_end_o  output  1  one-cycle pulse when x==H_VISIBLE-1 on a visible line
frame_count_o  output  8  frames started since reset, wraps 255->0
hsync_n_o  output  1  active-low hsync, delayed SYNC_DELAY cycles
vsync_n_o  output  1  active-low vsync, delayed SYNC_DELAY cycles
blank_n_o  output  1  active-low blank (1 = visible), delayed SYNC_DELAY cycles

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (reset_i=0, async): x=H_TOTAL-1, y=V_TOTAL-1, visible=0, frame_start_o=0, line_end_o=0, frame_count_o=0, hsync_n_o=1, vsync_n_o=1, blank_n_o=0. Every SYNC_DELAY stage resets to the same inactive values.
- Horizontal counter: x increments by 1 each clock; when x==H_TOTAL-1, x wraps to 0.
- Vertical counter: y increments on the x wrap; when y==V_TOTAL-1 and x wraps, y wraps to 0.
- First edge after reset release: coordinates become (0,0), visible=1, frame_start_o=1, and frame_count_o becomes 1.
- Timing of registered outputs: all outputs are registered, and the visible flag, strobes and syncs are computed from next-state counts. The flag and strobes are therefore coincident with the coordinates they describe, with zero skew versus x/y.
- Raw syncs, relative to the current x/y:
  - hsync low iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (x = 656..751).
  - vsync low iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (y = 490..491), for the whole of each such line.
- Raw blank_n equals the visible flag.
- Delay line: raw hsync/vsync/blank pass through a SYNC_DELAY-deep shift register. SYNC_DELAY=0 means they are coincident with x/y.
- frame_start_o: high exactly one cycle per frame, on the cycle x==0 and y==0.
- frame_count_o: increments on the same edge that raises frame_start_o.
- line_end_o: high exactly one cycle per visible line, so 480 pulses per frame; no pulse on blanking lines.
- Coordinates outside the visible region are not clamped; downstream must qualify with is_inside_visible_region_o.
- Reset mid-frame: all state returns immediately to reset values. The frame restarts at (0,0) on the first edge after release, and frame_count_o restarts at 1.
- No handshake, stall or enable: the generator is free-running whenever reset is high.

Test Plan:
- Release reset, run 1 clock -> x=0, y=0, visible=1, frame_start_o=1, frame_count_o=1, hsync_n_o=1, vsync_n_o=1; with SYNC_DELAY=1, blank_n_o=0 on this cycle and 1 on the next.
- Run 800 clocks from (0,0) -> x=0, y=1. line_end_o pulses once, at x=639/y=0. hsync (SYNC_DELAY=0) is low for exactly 96 clocks, beginning at x=656.
- Run one full frame (420000 clocks) -> exactly one frame_start_o pulse and 480 line_end_o pulses. vsync_n_o is low for exactly 1600 clocks, covering y=490..491. visible is high for exactly 307200 clocks.
- At x=799, y=524 -> next cycle is x=0, y=0, frame_start_o=1. Run 256 frames -> frame_count_o wraps from 255 to 0, then continues to 1.
- Assert reset at x=300, y=200 for 3 clocks, then release -> outputs take reset values asynchronously (before the next edge). First edge after release gives (0,0) and frame_count_o=1.
- SYNC_DELAY=3 -> hsync_n_o/vsync_n_o/blank_n_o equal the SYNC_DELAY=0 waveforms shifted by exactly 3 clocks; x/y/visible are unchanged.
